// File: rtl/psram_transaction_sequencer_pkg.sv
// Shared PSRAM definitions: sequencer state codes and PSRAM command bytes.
// Latency: none, constants and a pure helper function only.
// Backpressure: not applicable.
package psram_transaction_sequencer_pkg;

  // Sequencer states. Plain constants keep the encoding visible in waveforms
  // and stable for legacy tooling that decodes the state register.
  localparam logic [3:0] ST_INIT_WAIT = 4'd0;
  localparam logic [3:0] ST_RST_EN    = 4'd1;
  localparam logic [3:0] ST_RST_GAP   = 4'd2;
  localparam logic [3:0] ST_RST       = 4'd3;
  localparam logic [3:0] ST_IDLE      = 4'd4;
  localparam logic [3:0] ST_CMD       = 4'd5;
  localparam logic [3:0] ST_ADDR2     = 4'd6;
  localparam logic [3:0] ST_ADDR1     = 4'd7;
  localparam logic [3:0] ST_ADDR0     = 4'd8;
  localparam logic [3:0] ST_DATA      = 4'd9;
  localparam logic [3:0] ST_DESELECT  = 4'd10;

  // PSRAM command bytes.
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;

  // True in states that own an in-flight byte on the SPI engine.
  function automatic logic is_byte_state(input logic [3:0] st);
    return (st == ST_RST_EN) || (st == ST_RST)   || (st == ST_CMD)   ||
           (st == ST_ADDR2)  || (st == ST_ADDR1) || (st == ST_ADDR0) ||
           (st == ST_DATA);
  endfunction

endpackage

// File: rtl/psram_transaction_sequencer.sv
// PSRAM transaction sequencer: power-up reset (0x66/0x99) then one 5-byte SPI frame per request.
// Latency: CMD byte launches the cycle after acceptance; rsp_valid pulses the cycle after DATA byte_done.
// Backpressure: req_ready only in IDLE after init; every byte waits for byte_done from the byte engine.
module psram_transaction_sequencer
  import psram_transaction_sequencer_pkg::*;
#(
  parameter int INIT_WAIT_CYCLES = 4050,
  parameter int CE_HIGH_CYCLES   = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [22:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        init_done,
  output logic        ce,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx
);

  // One counter serves the power-up wait and both ce-high gaps, so size it
  // for whichever is longer.
  localparam int CNT_MAX = (INIT_WAIT_CYCLES > CE_HIGH_CYCLES) ? INIT_WAIT_CYCLES : CE_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CE_HIGH_CYCLES - 1);

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             launch;      // enter a byte state: pulse byte_start, drive byte_tx
  logic [7:0]       launch_byte;
  logic             frame_end;   // last byte of a frame acknowledged: raise ce
  logic             accept;
  logic             rsp_fire;
  logic             set_init;
  logic             byte_ack;
  logic             write_q;
  logic [22:0]      addr_q;
  logic [7:0]       wdata_q;

  assign req_ready = (state == ST_IDLE) && init_done;
  assign accept    = req_valid && req_ready;
  // A done in the launch cycle or outside a byte state cannot belong to our byte.
  assign byte_ack  = byte_done && !byte_start && is_byte_state(state);

  // Next-state decode: one byte per byte state, counted waits elsewhere.
  always_comb begin
    state_nx    = state;
    cnt_nx      = '0;
    launch      = 1'b0;
    launch_byte = 8'h00;
    frame_end   = 1'b0;
    rsp_fire    = 1'b0;
    set_init    = 1'b0;
    case (state)
      ST_INIT_WAIT: begin
        if (cnt == INIT_LAST) begin
          state_nx = ST_RST_EN; launch = 1'b1; launch_byte = CMD_RST_EN;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_RST_EN: if (byte_ack) begin state_nx = ST_RST_GAP; frame_end = 1'b1; end
      ST_RST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_RST; launch = 1'b1; launch_byte = CMD_RST;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_RST: if (byte_ack) begin state_nx = ST_DESELECT; frame_end = 1'b1; end
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_CMD; launch = 1'b1;
          launch_byte = req_write ? CMD_WRITE : CMD_READ;
        end
      end
      ST_CMD: if (byte_ack) begin
        state_nx = ST_ADDR2; launch = 1'b1; launch_byte = {1'b0, addr_q[22:16]};
      end
      ST_ADDR2: if (byte_ack) begin
        state_nx = ST_ADDR1; launch = 1'b1; launch_byte = addr_q[15:8];
      end
      ST_ADDR1: if (byte_ack) begin
        state_nx = ST_ADDR0; launch = 1'b1; launch_byte = addr_q[7:0];
      end
      ST_ADDR0: if (byte_ack) begin
        state_nx = ST_DATA; launch = 1'b1; launch_byte = write_q ? wdata_q : 8'h00;
      end
      ST_DATA: if (byte_ack) begin
        state_nx = ST_DESELECT; frame_end = 1'b1; rsp_fire = 1'b1;
      end
      ST_DESELECT: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_IDLE; set_init = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_INIT_WAIT;
    endcase
  end

  // State and shared wait counter.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered outputs toward the byte engine and the requester.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ce         <= 1'b1;
      byte_start <= 1'b0;
      byte_tx    <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      init_done  <= 1'b0;
    end else begin
      byte_start <= launch;
      rsp_valid  <= rsp_fire;
      if (launch) begin
        byte_tx <= launch_byte;
        ce      <= 1'b0;
      end else if (frame_end) begin
        ce      <= 1'b1;
      end
      if (rsp_fire && !write_q) rsp_rdata <= byte_rx;
      if (set_init)             init_done <= 1'b1;
    end
  end

  // Capture the request so the requester may change its inputs after acceptance.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: doc/psram_transaction_sequencer.md
PSRAM_TRANSACTION_SEQUENCER -- requirements
Module: psram_transaction_sequencer

Interface
REQ-001 Parameter INIT_WAIT_CYCLES, default 4050, sysclk cycles from reset release to first PSRAM command (150 us at 27 MHz).
REQ-002 Parameter CE_HIGH_CYCLES, default 2, minimum ce-high (deselect) cycles between any two PSRAM frames.
REQ-003 Ports: sysclk in 1, system clock; all logic on rising edge.
REQ-004 Ports: reset in 1, asynchronous active-high reset.
REQ-005 Ports: req_valid in 1, request offered; req_ready out 1, request accepted when both high.
REQ-006 Ports: req_write in 1, 1=write, 0=read; req_addr in 23, byte address; req_wdata in 8, write data.
REQ-007 Ports: rsp_valid out 1, one-cycle completion pulse; rsp_rdata out 8, read data.
REQ-008 Ports: init_done out 1, PSRAM reset sequence complete.
REQ-009 Ports: ce out 1, PSRAM chip enable, active-low.
REQ-010 Ports: byte_start out 1, byte_tx out 8, byte_done in 1, byte_rx in 8; handshake to the downstream SPI byte engine.

Function
REQ-011 States SHALL be: INIT_WAIT, RST_EN, RST_GAP, RST, IDLE, CMD, ADDR2, ADDR1, ADDR0, DATA, DESELECT.
REQ-012 INIT_WAIT counts INIT_WAIT_CYCLES, then enters RST_EN; ce high throughout.
REQ-013 Every byte state SHALL assert byte_start for exactly one cycle on entry with byte_tx valid that cycle, then hold byte_tx and wait for byte_done.
REQ-014 byte_done outside a byte-wait SHALL be ignored; byte_start SHALL never reassert before byte_done of the prior byte.
REQ-015 RST_EN sends 0x66 as a single-byte frame; RST_GAP holds ce high CE_HIGH_CYCLES; RST sends 0x99; then DESELECT, then IDLE with init_done=1.
REQ-016 req_ready SHALL be 1 only in IDLE with init_done=1; on acceptance req_write, req_addr and req_wdata are registered and state moves to CMD next cycle.
REQ-017 CMD sends 0x03 (read) or 0x02 (write); ADDR2/ADDR1/ADDR0 send {1'b0,addr[22:16]}, addr[15:8], addr[7:0].
REQ-018 DATA sends registered wdata for writes, 0x00 for reads.
REQ-019 ce SHALL go low the cycle byte_start first asserts in a frame and return high the cycle after byte_done of the frame's last byte.
REQ-020 On DATA byte_done: reads register byte_rx into rsp_rdata; rsp_valid pulses the following cycle for both reads and writes; rsp_rdata unchanged on writes.
REQ-021 DESELECT holds ce high CE_HIGH_CYCLES then enters IDLE; req_ready SHALL be 0 during DESELECT.
REQ-022 Back-to-back requests: minimum request-to-request spacing SHALL be 5 byte times + CE_HIGH_CYCLES + 2 cycles.
REQ-023 req_addr bit 22 wraps nowhere: addresses 0x7FFFFF and 0x000000 SHALL be sent verbatim, no increment logic.

Reset
REQ-024 Asserting reset, including mid-frame, SHALL immediately force ce=1, byte_start=0, req_ready=0, rsp_valid=0, init_done=0, byte_tx=0x00, rsp_rdata=0x00, state INIT_WAIT, counter cleared.
REQ-025 After reset release the full INIT_WAIT and 0x66/0x99 sequence SHALL repeat.

Structure
REQ-026 State enum and command constants (0x66, 0x99, 0x03, 0x02) SHALL live in the shared PSRAM package.
REQ-027 No sub-module; single FSM plus one shared cycle counter for INIT_WAIT, RST_GAP and DESELECT.

Verification
REQ-028 Reset, INIT_WAIT_CYCLES=10, engine acks each byte after 9 cycles -> byte 0x66 at cycle 10, ce high >=2 cycles, 0x99, init_done=1, req_ready=1.
REQ-029 Write addr 0x123456 data 0xA5 -> byte sequence 0x02,0x12,0x34,0x56,0xA5 under one ce-low window, rsp_valid one cycle after last byte_done.
REQ-030 Read addr 0x7FFFFF, engine returns 0x3C on DATA -> sequence 0x03,0x7F,0xFF,0xFF,0x00, rsp_rdata=0x3C with rsp_valid pulse.
REQ-031 req_valid held high continuously with two requests -> second accepted only after DESELECT, ce high >=CE_HIGH_CYCLES between frames.
REQ-032 Spurious byte_done in IDLE and reset asserted during ADDR1 -> no state change; ce=1 immediately, init sequence restarts.
REQ-033 Assertions: at most one byte_start per byte_done; ce never low in IDLE/INIT_WAIT/DESELECT.
